// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field positions, ID widths, ejector state encodings
// and the SrcID-to-source-index helper.
package noc_pkg;

  localparam int ID_W        = 10;
  localparam int NODE_ID_W   = 6;

  localparam int PKT_ID_MSB   = 25;
  localparam int PKT_ID_LSB   = 16;
  localparam int PKT_SRC_MSB  = 15;
  localparam int PKT_SRC_LSB  = 10;
  localparam int PKT_INFO_MSB = 9;
  localparam int PKT_INFO_LSB = 0;

  typedef enum logic [1:0] {
    EJ_IDLE    = 2'b00,
    EJ_ACK     = 2'b01,
    EJ_RELEASE = 2'b10
  } ej_state_e;

  // SrcID is {row[2:0], col[2:0]}; index is row-major across the mesh.
  function automatic int src_index(input logic [NODE_ID_W-1:0] src, input int mesh_x);
    return int'(src[5:3]) * mesh_x + int'(src[2:0]);
  endfunction

endpackage

// File: rtl/ejector_fifo.sv
// Receive buffer for the ejector: power-of-2 depth circular FIFO with occupancy count.
module ejector_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == (PTR_W+1)'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/noc_ejector.sv
// Mesh-node packet sink: Req/Gnt/Full handshake, receive FIFO, packet counter and
// optional per-source PacketID sequence check (enable with NOC_EJECTOR_SEQ_CHECK_EN).
module noc_ejector
  import noc_pkg::*;
#(
  parameter logic [5:0] routerID    = 6'b000_010,
  parameter int         packetwidth = 56,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         MESH_X      = 3,
  parameter int         NUM_SRC     = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqUpStr,
  input  logic [packetwidth-1:0] PacketIn,
  output logic                   GntUpStr,
  output logic                   UpStrFull,
  output logic                   PktValid,
  output logic [packetwidth-1:0] PktData,
  input  logic                   PktRead,
  output logic [15:0]            PktCount,
  output logic [15:0]            SeqErrCount
);

  ej_state_e                  r_state;
  logic                       r_gnt;
  logic [15:0]                r_pkt_cnt;
  logic                       w_accept;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                       w_unused_cfg;

  assign w_unused_cfg = ^{routerID, w_count};

  assign w_accept = (r_state == EJ_IDLE) && ReqUpStr && !w_full;
  assign w_pop    = PktRead && !w_empty;

  ejector_fifo #(
    .WIDTH (packetwidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_accept),
    .wr_data (PacketIn),
    .rd_en   (w_pop),
    .rd_data (PktData),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // A held request is absorbed by RELEASE until the router drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= EJ_IDLE;
      r_gnt     <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      case (r_state)
        EJ_IDLE: begin
          if (w_accept) begin
            r_gnt   <= 1'b1;
            r_state <= EJ_ACK;
            if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end
        end
        EJ_ACK: begin
          r_gnt   <= 1'b0;
          r_state <= EJ_RELEASE;
        end
        EJ_RELEASE: begin
          if (!ReqUpStr) r_state <= EJ_IDLE;
        end
        default: begin
          r_gnt   <= 1'b0;
          r_state <= EJ_IDLE;
        end
      endcase
    end
  end

  assign GntUpStr  = r_gnt;
  assign UpStrFull = w_full;
  assign PktValid  = !w_empty;
  assign PktCount  = r_pkt_cnt;

`ifdef NOC_EJECTOR_SEQ_CHECK_EN
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [ID_W-1:0]      r_seq_tbl [NUM_SRC];
  logic [15:0]          r_err_cnt;
  logic [NODE_ID_W-1:0] w_src;
  logic [ID_W-1:0]      w_rx_id;
  int                   w_idx;
  logic                 w_src_ok;
  logic [IDX_W-1:0]     w_idx_c;
  logic [ID_W-1:0]      w_exp_id;
  logic                 w_seq_err;

  always_comb begin
    w_src     = PacketIn[PKT_SRC_MSB:PKT_SRC_LSB];
    w_rx_id   = PacketIn[PKT_ID_MSB:PKT_ID_LSB];
    w_idx     = src_index(w_src, MESH_X);
    w_src_ok  = (int'(w_src[2:0]) < MESH_X) && (w_idx < NUM_SRC);
    w_idx_c   = w_src_ok ? IDX_W'(w_idx) : '0;
    w_exp_id  = r_seq_tbl[w_idx_c] + 10'd1;
    w_seq_err = !w_src_ok || (w_rx_id != w_exp_id);
  end

  // Table always follows the received ID so a single gap is counted once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_seq_tbl[i] <= '0;
    end else if (w_accept) begin
      if (w_src_ok) r_seq_tbl[w_idx_c] <= w_rx_id;
      if (w_seq_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign SeqErrCount = r_err_cnt;
`else
  logic w_unused_seq;
  assign w_unused_seq = ^{MESH_X, NUM_SRC};
  assign SeqErrCount  = '0;
`endif

endmodule

// File: tb/tb_noc_ejector.sv
// Directed bench for noc_ejector: handshake, FIFO fill/drain, sequence checking
// (expectations follow NOC_EJECTOR_SEQ_CHECK_EN) and asynchronous reset mid-handshake.
module tb_noc_ejector;

  logic        clk;
  logic        reset;
  logic        ReqUpStr;
  logic [55:0] PacketIn;
  logic        GntUpStr;
  logic        UpStrFull;
  logic        PktValid;
  logic [55:0] PktData;
  logic        PktRead;
  logic [15:0] PktCount;
  logic [15:0] SeqErrCount;

  int total;
  int bad;

  noc_ejector dut (
    .clk         (clk),
    .reset       (reset),
    .ReqUpStr    (ReqUpStr),
    .PacketIn    (PacketIn),
    .GntUpStr    (GntUpStr),
    .UpStrFull   (UpStrFull),
    .PktValid    (PktValid),
    .PktData     (PktData),
    .PktRead     (PktRead),
    .PktCount    (PktCount),
    .SeqErrCount (SeqErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] src;
    logic [9:0] id;
    int         exp_cnt;
    int         exp_err;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [55:0] mk(input logic [5:0] src, input logic [9:0] id);
    return {30'h2AAA_5555, id, src, 10'h13C};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a packet, waits (bounded) for the grant, then completes the release phase.
  task automatic send_pkt(input logic [55:0] pkt, input string name);
    bit got;
    got      = 1'b0;
    ReqUpStr = 1'b1;
    PacketIn = pkt;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (GntUpStr) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
    ReqUpStr = 1'b0;
    step();
    step();
  endtask

  task automatic pop();
    PktRead = 1'b1;
    step();
    PktRead = 1'b0;
  endtask

  function automatic int seq_exp(input int e);
`ifdef NOC_EJECTOR_SEQ_CHECK_EN
    return e;
`else
    return 0 * e;
`endif
  endfunction

  initial begin
    int gnts;
    bit got;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    ReqUpStr = 1'b0;
    PacketIn = '0;
    PktRead  = 1'b0;

    vecs[0] = '{6'b000_001, 10'd1, 6,  0};
    vecs[1] = '{6'b000_001, 10'd2, 7,  0};
    vecs[2] = '{6'b000_001, 10'd4, 8,  1};
    vecs[3] = '{6'b000_001, 10'd5, 9,  1};
    vecs[4] = '{6'b000_001, 10'd5, 10, 2};
    vecs[5] = '{6'b000_011, 10'd7, 11, 3};
    vecs[6] = '{6'b000_000, 10'd6, 12, 3};
    vecs[7] = '{6'b010_010, 10'd1, 13, 3};
    vecs[8] = '{6'b011_000, 10'd1, 14, 4};

    repeat (3) step();
    chk("rst_gnt",   64'(GntUpStr),    64'd0);
    chk("rst_full",  64'(UpStrFull),   64'd0);
    chk("rst_valid", 64'(PktValid),    64'd0);
    chk("rst_cnt",   64'(PktCount),    64'd0);
    chk("rst_err",   64'(SeqErrCount), 64'd0);
    reset = 1'b0;
    step();

    // First packet: grant exactly one cycle, one edge after Req is sampled
    ReqUpStr = 1'b1;
    PacketIn = mk(6'b000_000, 10'd1);
    step();
    chk("gnt_hi",     64'(GntUpStr), 64'd1);
    chk("p1_valid",   64'(PktValid), 64'd1);
    chk("p1_cnt",     64'(PktCount), 64'd1);
    chk("p1_err",     64'(SeqErrCount), 64'd0);
    step();
    chk("gnt_lo",     64'(GntUpStr), 64'd0);
    gnts = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (GntUpStr) gnts++;
    end
    chk("hold_no_gnt", 64'(gnts), 64'd0);
    chk("hold_cnt",    64'(PktCount), 64'd1);
    ReqUpStr = 1'b0;
    step();
    send_pkt(mk(6'b000_000, 10'd2), "p2_gnt");
    chk("p2_cnt",  64'(PktCount), 64'd2);
    chk("p2_head", 64'(PktData), 64'(mk(6'b000_000, 10'd1)));

    // Fill to full, then a blocked request released by one pop
    send_pkt(mk(6'b000_000, 10'd3), "p3_gnt");
    chk("p3_nfull", 64'(UpStrFull), 64'd0);
    send_pkt(mk(6'b000_000, 10'd4), "p4_gnt");
    chk("full_set", 64'(UpStrFull), 64'd1);
    ReqUpStr = 1'b1;
    PacketIn = mk(6'b000_000, 10'd5);
    gnts = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (GntUpStr) gnts++;
    end
    chk("full_no_gnt", 64'(gnts), 64'd0);
    chk("full_cnt",    64'(PktCount), 64'd4);
    chk("full_head",   64'(PktData), 64'(mk(6'b000_000, 10'd1)));
    pop();
    chk("pop_nfull", 64'(UpStrFull), 64'd0);
    chk("pop_head",  64'(PktData), 64'(mk(6'b000_000, 10'd2)));
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      if (GntUpStr) got = 1'b1;
    end
    chk("pend_gnt", 64'(got), 64'd1);
    ReqUpStr = 1'b0;
    step();
    step();
    chk("p5_cnt",   64'(PktCount), 64'd5);
    chk("p5_full",  64'(UpStrFull), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("drain_data", 64'(PktData), 64'(mk(6'b000_000, 10'(i))));
      pop();
    end
    chk("drain_empty", 64'(PktValid), 64'd0);
    pop();
    chk("empty_pop_valid", 64'(PktValid), 64'd0);
    chk("empty_pop_full",  64'(UpStrFull), 64'd0);
    chk("seq_clean", 64'(SeqErrCount), 64'd0);

    // Sequence-check vectors
    for (int i = 0; i < 9; i++) begin
      send_pkt(mk(vecs[i].src, vecs[i].id), "vec_gnt");
      chk("vec_data", 64'(PktData),     64'(mk(vecs[i].src, vecs[i].id)));
      chk("vec_cnt",  64'(PktCount),    64'(vecs[i].exp_cnt));
      chk("vec_err",  64'(SeqErrCount), 64'(seq_exp(vecs[i].exp_err)));
      pop();
    end
    chk("vec_empty", 64'(PktValid), 64'd0);

    // Asynchronous reset while in ACK
    ReqUpStr = 1'b1;
    PacketIn = mk(6'b000_010, 10'd9);
    step();
    chk("ack_gnt", 64'(GntUpStr), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_gnt",   64'(GntUpStr), 64'd0);
    chk("arst_valid", 64'(PktValid), 64'd0);
    chk("arst_cnt",   64'(PktCount), 64'd0);
    ReqUpStr = 1'b0;
    reset    = 1'b0;
    step();
    send_pkt(mk(6'b000_000, 10'd1), "post_rst_gnt");
    chk("post_rst_cnt",  64'(PktCount), 64'd1);
    chk("post_rst_err",  64'(SeqErrCount), 64'd0);
    chk("post_rst_data", 64'(PktData), 64'(mk(6'b000_000, 10'd1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
